// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame geometry, timing
// conversion and parity helpers, plus common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE,
        ERROR
    } Ps2TxState_t;

    localparam int PS2_FRAME_BITS = 10;
    localparam int HZ_PER_MHZ     = 1000000;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Integer MHz first so large TIMEOUT_US values stay inside 32 bits.
    function automatic int us_to_cycles(input int clock_hz, input int us);
        return clock_hz / HZ_PER_MHZ * us;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw open-drain PS/2 line and accepts a level change only
// after it has held for FILTER_LEN cycles; flags the accepted 1->0 edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out,
    output logic fall
);

    localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= 2'b11;
            line_out <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            // Any cycle agreeing with the current output restarts the run.
            if (sync[1] == line_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                line_out <= sync[1];
                cnt      <= '0;
                fall     <= line_out;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command sender: inhibit, start bit, 8 data bits, odd
// parity, stop, device ACK, with a watchdog on the device clock.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int INHIBIT_US      = 100,
    parameter int TIMEOUT_US      = 15000,
    parameter int FILTER_LEN      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txReady,
    output logic       txDone,
    output logic       txError,
    output logic       rxInhibit,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkDriveLow,
    output logic       ps2DataDriveLow
);

    localparam int INHIBIT_CYCLES = us_to_cycles(CLOCK_FREQUENCY, INHIBIT_US);
    localparam int TIMEOUT_CYCLES = us_to_cycles(CLOCK_FREQUENCY, TIMEOUT_US);
    localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       IDX_STOP = 4'(PS2_FRAME_BITS - 1);

    Ps2TxState_t               state, state_n;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic [3:0]                idx;
    logic [INH_W-1:0]          inh_cnt;
    logic [WD_W-1:0]           wd_cnt;
    logic                      data_low;
    logic                      clk_f, clk_fall;
    logic                      data_f, data_fall_unused;
    logic                      wd_expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (ps2ClkIn),
        .line_out (clk_f),
        .fall     (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (ps2DataIn),
        .line_out (data_f),
        .fall     (data_fall_unused)
    );

    assign wd_expired = (wd_cnt == WD_LAST);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (txStart) state_n = INHIBIT;
            INHIBIT:   if (inh_cnt == INH_LAST) state_n = SEND;
            SEND: begin
                if (clk_fall) begin
                    if (idx == IDX_STOP) state_n = ACK;
                end else if (wd_expired) begin
                    state_n = ERROR;
                end
            end
            ACK: begin
                if (clk_fall)        state_n = data_f ? ERROR : WAIT_IDLE;
                else if (wd_expired) state_n = ERROR;
            end
            WAIT_IDLE: begin
                if (clk_f && data_f) state_n = IDLE;
                else if (wd_expired) state_n = ERROR;
            end
            ERROR:     state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            frame    <= '0;
            idx      <= '0;
            inh_cnt  <= '0;
            wd_cnt   <= '0;
            data_low <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (txStart) begin
                        frame   <= {1'b1, odd_parity(txData), txData};
                        idx     <= '0;
                        inh_cnt <= '0;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    wd_cnt  <= '0;
                end
                SEND, ACK, WAIT_IDLE: begin
                    wd_cnt <= clk_fall ? '0 : wd_cnt + 1'b1;
                    if (state == SEND && clk_fall) begin
                        data_low <= ~frame[idx];
                        idx      <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
            // Start bit is held into SEND until the device's first clock.
            if (state == INHIBIT && state_n == SEND) data_low <= 1'b1;
            if (state_n inside {ACK, ERROR, IDLE})   data_low <= 1'b0;
        end
    end

    assign txReady         = (state == IDLE);
    assign txDone          = (state == WAIT_IDLE) && clk_f && data_f;
    assign txError         = (state == ERROR);
    assign rxInhibit       = (state inside {INHIBIT, SEND, ACK, WAIT_IDLE}) && !txDone;
    assign ps2ClkDriveLow  = (state == INHIBIT);
    assign ps2DataDriveLow = data_low || (state == INHIBIT && inh_cnt == INH_LAST);

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Scoreboarded bench: a PS/2 device model clocks the frame in over an
// open-drain bus; a monitor checks each done/error pulse against a queue.
module tb_ps2_host_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txReady, txDone, txError, rxInhibit;
    logic       ps2ClkDriveLow, ps2DataDriveLow;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_bus, ps2_data_bus;

    assign ps2_clk_bus  = dev_clk & ~ps2ClkDriveLow;
    assign ps2_data_bus = dev_data & ~ps2DataDriveLow;

    ps2_host_transmitter #(
        .CLOCK_FREQUENCY (1000000),
        .INHIBIT_US      (100),
        .TIMEOUT_US      (15000),
        .FILTER_LEN      (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .txStart         (txStart),
        .txData          (txData),
        .txReady         (txReady),
        .txDone          (txDone),
        .txError         (txError),
        .rxInhibit       (rxInhibit),
        .ps2ClkIn        (ps2_clk_bus),
        .ps2DataIn       (ps2_data_bus),
        .ps2ClkDriveLow  (ps2ClkDriveLow),
        .ps2DataDriveLow (ps2DataDriveLow)
    );

    initial forever #500 clk = ~clk;

    // kind: 0 = device ACKs, 1 = device withholds ACK, 2 = device silent
    typedef struct {
        int         kind;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         send_cyc = 0;
    int         low_len = 0;
    logic       prev_cdl = 1'b0;
    logic [9:0] bfm_frame = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wire frame from first principles: LSB-first data, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'((d >> i) & 8'd1);
        return 10'(d) + ((ones % 2 == 0) ? 10'h100 : 10'h000) + 10'h200;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inhibit-length check and SEND-entry timestamp for the watchdog test.
    initial forever begin
        @(negedge clk);
        if (ps2ClkDriveLow) begin
            low_len++;
        end else if (low_len > 0) begin
            chk("inhibit_len", low_len, 100);
            low_len = 0;
        end
        if (prev_cdl && !ps2ClkDriveLow) send_cyc = cyc;
        prev_cdl = ps2ClkDriveLow;
    end

    initial forever begin
        @(negedge clk);
        if (txDone || txError) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", txDone, txError);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_flag", int'(txDone), int'(e.kind == 0));
                chk("error_flag", int'(txError), int'(e.kind != 0));
                chk("rx_inhibit_at_end", int'(rxInhibit), 0);
                if (e.kind == 2) chk("timeout_cycles", cyc - send_cyc, 15000);
                else             chk("wire_frame", int'(bfm_frame), int'(e.frame));
            end
        end
    end

    initial begin
        #200000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        chk("accept_inhibit", int'(rxInhibit), 1);
        chk("accept_busy", int'(txReady), 0);
    endtask

    task automatic wait_ready(input int max_cycles);
        int n = 0;
        while (!txReady && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return", int'(txReady), 1);
    endtask

    // Device side: waits for request-to-send, then 11 clocks of 40 cycles.
    task automatic dev_xfer(input int mode, input int abort_bit);
        logic [9:0] cap = '0;
        int         n = 0;
        while (!(ps2_clk_bus && !ps2_data_bus) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            tests++;
            fails++;
            $display("FAIL rts_wait: no request-to-send within %0d cycles", n);
            return;
        end
        if (mode == 2) return;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (i == abort_bit) return;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            cap[i]  = ps2_data_bus;
            repeat (20) @(negedge clk);
        end
        bfm_frame = cap;
        dev_data  = (mode == 0) ? 1'b0 : 1'b1;
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_tx(input logic [7:0] d, input int kind);
        exp_t e;
        e.kind    = kind;
        e.frame   = model_frame(d);
        bfm_frame = '0;
        exp_q.push_back(e);
        start_tx(d);
        dev_xfer(kind, -1);
        wait_ready(kind == 2 ? 16000 : 300);
        repeat (3) @(negedge clk);
        chk("idle_rx_inhibit", int'(rxInhibit), 0);
        chk("idle_lines", int'({ps2ClkDriveLow, ps2DataDriveLow}), 0);
    endtask

    initial begin
        logic [7:0] d;
        exp_t       e;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({txReady, txDone, txError, rxInhibit, ps2ClkDriveLow, ps2DataDriveLow}),
            int'(6'b100000));
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_tx(8'hED, 0);
        run_tx(8'h00, 0);
        run_tx(8'h01, 0);
        for (int i = 0; i < 6; i++) run_tx(8'($urandom_range(0, 255)), 0);
        run_tx(8'($urandom_range(0, 255)), 1);
        run_tx(8'($urandom_range(0, 255)), 2);
        chk("timeout_ready", int'(txReady), 1);

        // Asynchronous reset while the host drives data bit 4 low.
        d = 8'($urandom_range(0, 255)) & 8'hEF;
        bfm_frame = '0;
        start_tx(d);
        dev_xfer(0, 4);
        chk("bit4_driven", int'(ps2DataDriveLow), 1);
        #100 rst = 1'b0;
        #1 chk("async_release", int'({ps2ClkDriveLow, ps2DataDriveLow}), 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", int'(txReady), 1);
        run_tx(8'hFF, 0);

        // A second request mid-frame must be dropped.
        d = 8'($urandom_range(0, 255));
        if (d == 8'hAA) d = 8'h55;
        e.kind    = 0;
        e.frame   = model_frame(d);
        bfm_frame = '0;
        exp_q.push_back(e);
        start_tx(d);
        fork
            dev_xfer(0, -1);
            begin
                repeat (250) @(negedge clk);
                txData  = 8'hAA;
                txStart = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
            end
        join
        wait_ready(300);
        repeat (300) @(negedge clk);
        chk("no_requeue", int'({ps2ClkDriveLow, txReady}), 1);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
